// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux select sequencer.
// Channel k is selected by {s1,s0} = k; the scan walks channels 0..NUM_CH-1.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    // A single-cycle dwell still needs a 1-bit counter that simply sits at zero.
    function automatic int dwell_width(input int dwell);
        return (dwell > 1) ? $clog2(dwell) : 1;
    endfunction

endpackage

// File: rtl/mux_dwell_cnt.sv
// Dwell counter: counts cycles spent on one channel while enabled and pulses tc
// on the last cycle of each dwell. clr holds the count at zero outside a scan.
module mux_dwell_cnt
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tc
);

    localparam int            CW   = dwell_width(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tc = en && !clr && (cnt == LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Select sequencer for a 4:1 mux: walks {s1,s0} over all channels, samples y once per
// channel and hands the packed 4-bit word to a consumer over valid/ready.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 2,
    parameter bit CONT  = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mux_y,
    output logic              s1,
    output logic              s0,
    output logic              busy,
    output logic [NUM_CH-1:0] out_word,
    output logic              out_valid,
    input  logic              out_ready
);

    scan_state_t     state;
    logic [CH_W-1:0] ch;
    logic            scanning;
    logic            tc;

    assign scanning = (state == SCAN);

    mux_dwell_cnt #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (scanning),
        .clr   (!scanning),
        .tc    (tc)
    );

    // ch is the select register itself, so the mux sees glitch-free registered selects.
    assign {s1, s0} = ch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch        <= '0;
            out_word  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        ch    <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (tc) begin
                        out_word[ch] <= mux_y;
                        ch           <= ch + 1'b1;
                        if (ch == LAST_CH) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // Word and selects stay frozen for as long as the consumer stalls.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (CONT) begin
                            state <= SCAN;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    ch        <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three configurations (DWELL 2/1/3, CONT 0/1/0) against a
// cycle-level behavioural model, plus directed scenarios with hand-computed values.
module tb_mux_scan_ctrl;

    localparam int NU = 3;
    localparam int DW [NU] = '{2, 1, 3};
    localparam int CT [NU] = '{0, 1, 0};

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic [NU-1:0] start;
    logic [NU-1:0] out_ready;
    logic [NU-1:0] mux_y;
    logic [NU-1:0] s1;
    logic [NU-1:0] s0;
    logic [NU-1:0] busy;
    logic [NU-1:0] out_valid;
    logic [3:0]    out_word [NU];
    logic [3:0]    mux_in   [NU];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_scan_ctrl #(.DWELL(2), .CONT(1'b0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mux_y(mux_y[0]),
        .s1(s1[0]), .s0(s0[0]), .busy(busy[0]), .out_word(out_word[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0])
    );

    mux_scan_ctrl #(.DWELL(1), .CONT(1'b1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mux_y(mux_y[1]),
        .s1(s1[1]), .s0(s0[1]), .busy(busy[1]), .out_word(out_word[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1])
    );

    mux_scan_ctrl #(.DWELL(3), .CONT(1'b0)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .mux_y(mux_y[2]),
        .s1(s1[2]), .s0(s0[2]), .busy(busy[2]), .out_word(out_word[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2])
    );

    // Stand-in for the 4:1 mux under control.
    for (genvar g = 0; g < NU; g++) begin : g_mux
        assign mux_y[g] = mux_in[g][{s1[g], s0[g]}];
    end

    // Model: mode 0 idle, 1 scanning (m_e cycles elapsed since start edge), 2 word waiting.
    int         m_mode [NU];
    int         m_e    [NU];
    logic       m_valid[NU];
    logic [3:0] m_word [NU];

    task automatic modelReset();
        for (int i = 0; i < NU; i++) begin
            m_mode[i]  = 0;
            m_e[i]     = 0;
            m_valid[i] = 1'b0;
            m_word[i]  = 4'h0;
        end
    endtask

    task automatic modelStep(input int i);
        int cyc;
        int chn;
        case (m_mode[i])
            0: begin
                if (start[i]) begin
                    m_mode[i] = 1;
                    m_e[i]    = 0;
                end
            end
            1: begin
                cyc = m_e[i] + 1;
                chn = (cyc - 1) / DW[i];
                if (cyc % DW[i] == 0) m_word[i][chn] = mux_in[i][chn];
                m_e[i] = cyc;
                if (cyc == 4 * DW[i]) begin
                    m_mode[i]  = 2;
                    m_valid[i] = 1'b1;
                end
            end
            default: begin
                if (out_ready[i]) begin
                    m_valid[i] = 1'b0;
                    if (CT[i] != 0) begin
                        m_mode[i] = 1;
                        m_e[i]    = 0;
                    end else begin
                        m_mode[i] = 0;
                    end
                end
            end
        endcase
    endtask

    initial modelReset();
    always @(negedge rst_n) modelReset();
    always @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NU; i++) modelStep(i);
        end
    end

    task automatic checkOutput(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", nm, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NU; i++) begin
            checkOutput($sformatf("u%0d.sel", i), {s1[i], s0[i]},
                        (m_mode[i] == 1) ? m_e[i] / DW[i] : 0);
            checkOutput($sformatf("u%0d.busy", i), busy[i], (m_mode[i] != 0) ? 1 : 0);
            checkOutput($sformatf("u%0d.valid", i), out_valid[i], m_valid[i]);
            checkOutput($sformatf("u%0d.word", i), out_word[i], m_word[i]);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < NU; i++) begin
            start[i] = ($urandom_range(0, 7) == 0);
            if (i != 1) out_ready[i] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) mux_in[i] = 4'($urandom_range(0, 15));
        end
    endtask

    initial begin
        int   sel2 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};
        int   sel5 [5] = '{0, 1, 2, 3, 0};
        logic prev_v;
        int   words;
        int   lat1;
        int   lat2;
        int   second;

        start     = '0;
        out_ready = '1;
        mux_in[0] = 4'b1101;
        mux_in[1] = 4'hA;
        mux_in[2] = 4'hA;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        checkOutput("reset.sel", {s1[0], s0[0]}, 0);
        checkOutput("reset.busy", busy[0], 0);
        checkOutput("reset.valid", out_valid[0], 0);
        checkOutput("reset.word", out_word[0], 0);

        // Reset in cycle 3 of a scan, after channel 0 has already been sampled.
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mid.sel", {s1[0], s0[0]}, 0);
        checkOutput("rst_mid.busy", busy[0], 0);
        checkOutput("rst_mid.word", out_word[0], 0);
        step();
        step();
        #2 rst_n = 1'b1;
        step();
        for (int c = 0; c < 10; c++) begin
            checkOutput("rst_after.valid", out_valid[0], 0);
            checkOutput("rst_after.busy", busy[0], 0);
            step();
        end

        // Single scan, DWELL=2, inputs i0..i3 = 1,0,1,1 with the consumer stalled.
        out_ready[0] = 1'b0;
        start[0]     = 1'b1;
        step();
        start[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checkOutput($sformatf("scan.sel%0d", c + 1), {s1[0], s0[0]}, sel2[c]);
            checkOutput("scan.valid_early", out_valid[0], 0);
            checkOutput("scan.busy", busy[0], 1);
            step();
        end
        checkOutput("scan.valid", out_valid[0], 1);
        checkOutput("scan.word", out_word[0], 4'b1101);
        checkOutput("scan.sel_done", {s1[0], s0[0]}, 0);
        checkOutput("scan.busy_done", busy[0], 1);

        mux_in[0] = 4'b0000;
        for (int c = 0; c < 10; c++) begin
            step();
            checkOutput("bp.valid", out_valid[0], 1);
            checkOutput("bp.word", out_word[0], 4'b1101);
            checkOutput("bp.sel", {s1[0], s0[0]}, 0);
        end
        out_ready[0] = 1'b1;
        step();
        checkOutput("bp.release_valid", out_valid[0], 0);
        checkOutput("bp.release_busy", busy[0], 0);
        mux_in[0] = 4'b1101;

        // Start pulses mid-scan, during DONE, and together with the handshake.
        out_ready[0] = 1'b0;
        start[0]     = 1'b1;
        step();
        prev_v = 1'b0;
        words  = 0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            start[0]     = (cyc == 3 || cyc == 9 || cyc == 12);
            out_ready[0] = (cyc == 12);
            step();
            if (out_valid[0] && !prev_v) words++;
            prev_v = out_valid[0];
        end
        start[0] = 1'b0;
        checkOutput("ign.words", words, 1);
        for (int c = 0; c < 12; c++) begin
            checkOutput("ign.busy", busy[0], 0);
            checkOutput("ign.valid", out_valid[0], 0);
            step();
        end

        // DWELL=1 continuous vs DWELL=3, same input pattern.
        start[1] = 1'b1;
        start[2] = 1'b1;
        step();
        start[1] = 1'b0;
        start[2] = 1'b0;
        lat1   = -1;
        lat2   = -1;
        second = -1;
        for (int n = 0; n < 40; n++) begin
            if (n < 5) checkOutput($sformatf("cont.sel%0d", n), {s1[1], s0[1]}, sel5[n]);
            if (out_valid[1] && lat1 < 0) begin
                lat1 = n;
                checkOutput("cont.word_a", out_word[1], 4'hA);
                mux_in[1] = 4'h5;
            end else if (out_valid[1] && lat1 >= 0 && n > lat1 + 1 && second < 0) begin
                second = n;
                checkOutput("cont.word_5", out_word[1], 4'h5);
            end
            if (out_valid[2] && lat2 < 0) begin
                lat2 = n;
                checkOutput("d3.word", out_word[2], 4'hA);
            end
            step();
        end
        checkOutput("d1.latency", lat1, 4);
        checkOutput("d3.latency", lat2, 12);
        checkOutput("cont.spacing", second - lat1, 5);

        // Randomised traffic with occasional resets; the compare process does the checking.
        for (int it = 0; it < 1500; it++) begin
            applyStimulus();
            if ($urandom_range(0, 199) == 0) begin
                #2 rst_n = 1'b0;
                @(posedge clk);
                #3 rst_n = 1'b1;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
